// File: rtl/mips_pkg.sv
// ============================================================================
// Module      : mips_pkg
// Description : Shared opcode constants, fetch-state encoding and reset PC.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mips_pkg;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    localparam logic [5:0] OP_RTYPE  = 6'b000000;
    // Jumps occupy 0100xx; OP_J is the canonical member, OP_J_MASK selects the fixed bits.
    localparam logic [5:0] OP_J      = 6'b010000;
    localparam logic [5:0] OP_J_MASK = 6'b111100;
    localparam logic [5:0] OP_LW     = 6'b011100;
    localparam logic [5:0] OP_SW     = 6'b011101;
    localparam logic [5:0] OP_BEQ    = 6'b100000;
    localparam logic [5:0] OP_BNE    = 6'b101000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        FAULT = 2'd3
    } fetch_state_t;

endpackage

`default_nettype wire

// File: rtl/next_pc.sv
// ============================================================================
// Module      : next_pc
// Description : Combinational next-PC selection (jump > taken branch > PC+4).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module next_pc
    import mips_pkg::*;
(
    input  logic [31:0] PC,
    input  logic [31:0] Instr,
    input  logic        Jump,
    input  logic        Branch,
    input  logic        Zero,
    output logic [31:0] NextPC
);

    logic [31:0] w_pc4;
    logic [31:0] w_br_off;
    logic [5:0]  w_op;
    logic        w_taken;

    assign w_pc4    = PC + 32'd4;
    assign w_br_off = {{14{Instr[15]}}, Instr[15:0], 2'b00};
    assign w_op     = Instr[31:26];

    // Only beq/bne can be taken; any other opcode with Branch set falls through.
    assign w_taken  = (w_op == OP_BEQ) ? Zero :
                      (w_op == OP_BNE) ? !Zero : 1'b0;

    always_comb begin
        NextPC = w_pc4;
        if (Jump) begin
            NextPC = {w_pc4[31:28], Instr[25:0], 2'b00};
        end else if (Branch && w_taken) begin
            NextPC = w_pc4 + w_br_off;
        end
    end

endmodule

`default_nettype wire

// File: rtl/fetch_unit.sv
// ============================================================================
// Module      : fetch_unit
// Description : Instruction fetch FSM with held instruction and PC update.
//               Optional fetch timeout enabled by defining FETCH_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC       = DEFAULT_RESET_PC,
    parameter int          TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    output logic        IMemReq,
    output logic [31:0] IMemAddr,
    input  logic        IMemReady,
    input  logic [31:0] IMemData,
    output logic [31:0] Instr,
    output logic [5:0]  Opcode,
    output logic [31:0] PC,
    output logic        InstrValid,
    input  logic        Advance,
    input  logic        Jump,
    input  logic        Branch,
    input  logic        Zero,
    output logic        Fault
);

    fetch_state_t r_state;
    fetch_state_t w_state_nxt;
    logic [31:0]  r_pc;
    logic [31:0]  r_instr;
    logic [31:0]  w_next_pc;
    logic         w_capture;
    logic         w_retire;

`ifdef FETCH_TIMEOUT_EN
    localparam int                c_tmo_width = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_tmo_width-1:0] c_tmo_limit = c_tmo_width'(TIMEOUT_CYCLES);

    logic [c_tmo_width-1:0] r_tmo_cnt;
    logic                   w_tmo_hit;

    assign w_tmo_hit = (r_tmo_cnt + c_tmo_width'(1)) == c_tmo_limit;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_tmo_cnt <= '0;
        end else if (r_state != FETCH && w_state_nxt == FETCH) begin
            r_tmo_cnt <= '0;
        end else if (r_state == FETCH && !IMemReady) begin
            r_tmo_cnt <= r_tmo_cnt + c_tmo_width'(1);
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        IMemReq     = 1'b0;
        InstrValid  = 1'b0;
        Fault       = 1'b0;
        w_capture   = 1'b0;
        w_retire    = 1'b0;
        case (r_state)
            IDLE: begin
                w_state_nxt = FETCH;
            end
            FETCH: begin
                IMemReq = 1'b1;
                if (IMemReady) begin
                    w_capture   = 1'b1;
                    w_state_nxt = HOLD;
                end
`ifdef FETCH_TIMEOUT_EN
                else if (w_tmo_hit) begin
                    w_state_nxt = FAULT;
                end
`endif
            end
            HOLD: begin
                InstrValid = 1'b1;
                if (Advance) begin
                    w_retire    = 1'b1;
                    w_state_nxt = FETCH;
                end
            end
`ifdef FETCH_TIMEOUT_EN
            FAULT: begin
                Fault = 1'b1;
            end
`endif
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Reset wins over a same-cycle IMemReady, so a late response is dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc    <= RESET_PC;
            r_instr <= 32'h0000_0000;
        end else begin
            if (w_capture) begin
                r_instr <= IMemData;
            end
            if (w_retire) begin
                r_pc <= w_next_pc;
            end
        end
    end

    next_pc u_next_pc (
        .PC     (r_pc),
        .Instr  (r_instr),
        .Jump   (Jump),
        .Branch (Branch),
        .Zero   (Zero),
        .NextPC (w_next_pc)
    );

    assign IMemAddr = r_pc;
    assign PC       = r_pc;
    assign Instr    = r_instr;
    assign Opcode   = r_instr[31:26];

endmodule

`default_nettype wire

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_0000, PC value loaded on reset.
REQ-002 Parameter: TIMEOUT_CYCLES, 16, FETCH cycles without IMemReady before fault (used only with FETCH_TIMEOUT_EN).
REQ-003 The module SHALL have one clock and a synchronous, active-high reset.
REQ-004 Port: clk  in  1  sole clock, rising edge.
REQ-005 Port: reset  in  1  synchronous, active-high reset.
REQ-006 Port: IMemReq  out  1  instruction-memory read request.
REQ-007 Port: IMemAddr  out  32  read address; equals PC.
REQ-008 Port: IMemReady  in  1  read data valid this cycle.
REQ-009 Port: IMemData  in  32  instruction word.
REQ-010 Port: Instr  out  32  held instruction.
REQ-011 Port: Opcode  out  6  Instr[31:26], feeds the main control decoder.
REQ-012 Port: PC  out  32  address of the held instruction.
REQ-013 Port: InstrValid  out  1  Instr/Opcode/PC are valid.
REQ-014 Port: Advance  in  1  datapath retires the held instruction.
REQ-015 Port: Jump, Branch, Zero  in  1 each  decoder outputs and ALU zero flag, sampled with Advance.
REQ-016 Port: Fault  out  1  sticky fetch timeout.

Function
REQ-017 The FSM SHALL have states IDLE, FETCH, HOLD and FAULT; IDLE->FETCH is unconditional after one cycle.
REQ-018 In FETCH, IMemReq SHALL be 1, IMemAddr SHALL equal PC, and both SHALL remain stable until IMemReady.
REQ-019 In FETCH with IMemReady=1, Instr SHALL capture IMemData and the FSM SHALL enter HOLD; InstrValid=1 the next cycle.
REQ-020 In HOLD with Advance=1, PC SHALL load NextPC and the FSM SHALL enter FETCH; IMemReq=1 the next cycle (minimum 2 cycles/instruction).
REQ-021 NextPC SHALL be: Jump=1 -> {PC4[31:28], Instr[25:0], 2'b00}; else Branch=1 and taken -> PC4 + (signext(Instr[15:0])<<2); else PC4, where PC4 = PC+4.
REQ-022 Taken SHALL be Zero for opcode 100000 (beq), !Zero for opcode 101000 (bne), and 0 for any other opcode.
REQ-023 Jump SHALL take priority over Branch when both are high.
REQ-024 All PC arithmetic SHALL be modulo 2^32: PC 32'hFFFF_FFFC advances to 32'h0000_0000.
REQ-025 Advance outside HOLD, and IMemReady outside FETCH, SHALL be ignored.
REQ-026 Instr, PC and InstrValid SHALL NOT change in HOLD until Advance.

Reset
REQ-027 On reset: state=IDLE, PC=RESET_PC, Instr=0, InstrValid=0, IMemReq=0, Fault=0, timeout counter=0.
REQ-028 Reset asserted mid-FETCH SHALL drop IMemReq in the following cycle, and any IMemReady in that reset cycle SHALL be discarded.

Configuration
REQ-029 With FETCH_TIMEOUT_EN defined: a counter cleared on FETCH entry SHALL increment each FETCH cycle without IMemReady; on reaching TIMEOUT_CYCLES the FSM SHALL enter FAULT.
REQ-030 In FAULT: Fault=1, IMemReq=0 and InstrValid=0 until reset.
REQ-031 Without FETCH_TIMEOUT_EN: no counter or FAULT state, FETCH waits indefinitely, and Fault is tied to 0.

Structure
REQ-032 Shared package mips_pkg SHALL hold opcode constants (OP_RTYPE 000000, OP_J 0100xx, OP_LW 011100, OP_SW 011101, OP_BEQ 100000, OP_BNE 101000), the fetch-state enum, and the RESET_PC default.
REQ-033 Next-PC computation SHALL be one combinational sub-module, next_pc, inputs PC/Instr/Jump/Branch/Zero, output NextPC.

Verification
REQ-034 Reset release with IMemReady tied to 1 -> IMemReq=1, IMemAddr=0 on cycle 2; InstrValid=1 on cycle 3.
REQ-035 Sequential: PC=0x100, Advance, Jump=0, Branch=0 -> next IMemAddr=0x104.
REQ-036 beq at PC=0x100, Instr[15:0]=0xFFFE, Zero=1 -> 0xFC; with Zero=0 -> 0x104; bne with Zero=0 and the same immediate -> 0xFC.
REQ-037 Jump at PC=0x1000_0000, Instr[25:0]=0x000_0040 -> IMemAddr=0x1000_0100; Jump=1 with Branch=1 -> jump target.
REQ-038 IMemReady held 0 for 5 cycles -> IMemAddr stable, InstrValid=0; with FETCH_TIMEOUT_EN and a 16-cycle stall -> Fault=1, IMemReq=0.
REQ-039 Reset pulse during FETCH with IMemReady=1 in the same cycle -> Instr=0, PC=RESET_PC, refetch from RESET_PC.
